// File: rtl/mips_cpu_mult_div.sv
// rtl/mips_cpu_mult_div.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI and LO registers
// Multiply is LSB-first shift-add, divide is MSB-first restoring; signs are stripped at start and restored at FINISH.
module mips_cpu_mult_div #(
    parameter int          WIDTH       = 32,
    parameter logic [31:0] DIV_ZERO_LO = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    localparam logic [4:0] LAST = 5'(WIDTH - 1);

    state_t               state, state_next;
    logic [4:0]           counter;
    logic                 is_div;
    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH-1:0]     shreg;
    logic [2*WIDTH-1:0]   acc;

    logic                 op_signed, in_sign_a, in_sign_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH+1:0]     div_diff;
    logic                 div_ok;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix, dividend_raw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else if (clk_enable)
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (counter == LAST) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    assign op_signed = ~op[0];
    assign in_sign_a = op_signed & operand_a[WIDTH-1];
    assign in_sign_b = op_signed & operand_b[WIDTH-1];

    // Multiply: shreg holds the remaining multiplier bits, acc the shifting product.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (shreg[0] ? {1'b0, mag_a} : '0);

    // Divide: shreg shifts the dividend out and quotient bits in; acc[WIDTH:0] is the partial remainder.
    assign div_shift = {acc[WIDTH-1:0], shreg[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
    assign div_ok    = ~div_diff[WIDTH+1];

    assign prod_fix     = (sign_a ^ sign_b) ? -acc : acc;
    assign quot_fix     = (sign_a ^ sign_b) ? -shreg : shreg;
    assign rem_fix      = sign_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign dividend_raw = sign_a ? -mag_a : mag_a;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter     <= '0;
            is_div      <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            mag_a       <= '0;
            mag_b       <= '0;
            shreg       <= '0;
            acc         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (clk_enable) begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        counter <= '0;
                        is_div  <= op[1];
                        sign_a  <= in_sign_a;
                        sign_b  <= in_sign_b;
                        mag_a   <= in_sign_a ? -operand_a : operand_a;
                        mag_b   <= in_sign_b ? -operand_b : operand_b;
                        shreg   <= op[1] ? (in_sign_a ? -operand_a : operand_a)
                                         : (in_sign_b ? -operand_b : operand_b);
                        acc     <= '0;
                    end else begin
                        if (wr_hi) hi <= wr_data;
                        if (wr_lo) lo <= wr_data;
                    end
                end
                CALC: begin
                    counter <= counter + 5'd1;
                    if (is_div) begin
                        acc   <= {{(WIDTH-1){1'b0}}, (div_ok ? div_diff[WIDTH:0] : div_shift)};
                        shreg <= {shreg[WIDTH-2:0], div_ok};
                    end else begin
                        acc   <= {mul_sum, acc[WIDTH-1:1]};
                        shreg <= {1'b0, shreg[WIDTH-1:1]};
                    end
                end
                FINISH: begin
                    done <= 1'b1;
                    if (!is_div) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (mag_b == '0) begin
                        hi          <= dividend_raw;
                        lo          <= DIV_ZERO_LO;
                        div_by_zero <= 1'b1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_mult_div.sv
// tb/tb_mips_cpu_mult_div.sv - self-checking bench for mips_cpu_mult_div
module tb_mips_cpu_mult_div;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b;
    logic        wr_hi, wr_lo;
    logic [31:0] wr_data;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mips_cpu_mult_div dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .wr_hi(wr_hi), .wr_lo(wr_lo),
        .wr_data(wr_data), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, exp_hi, exp_lo;
        logic        exp_dbz;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference results from plain 64-bit arithmetic (SV / and % truncate toward zero).
    task automatic model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l, output logic z);
        longint sa, sb, ua, ub, p, q, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        z  = 1'b0;
        p = 0; q = 0; r = 0;
        if (!mop[1]) begin
            p = mop[0] ? ua * ub : sa * sb;
            h = p[63:32];
            l = p[31:0];
        end else if (b == 32'd0) begin
            h = a;
            l = 32'hFFFFFFFF;
            z = 1'b1;
        end else begin
            q = mop[0] ? ua / ub : sa / sb;
            r = mop[0] ? ua % ub : sa % sb;
            h = r[31:0];
            l = q[31:0];
        end
    endtask

    task automatic run_op(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] h, output logic [31:0] l, output logic z,
                          output int lat, output logic busy_ok, output logic hold_ok);
        logic [31:0] hold_hi, hold_lo;
        hold_hi = hi;
        hold_lo = lo;
        start = 1'b1; op = mop; operand_a = a; operand_b = b;
        tick();
        start = 1'b0; operand_a = $urandom; operand_b = $urandom;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        lat = 0;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (hi !== hold_hi || lo !== hold_lo) hold_ok = 1'b0;
            tick();
            lat++;
        end
        if (busy) busy_ok = 1'b0;
        h = hi;
        l = lo;
        z = div_by_zero;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] h, l, mh, ml;
        logic        z, mz, busy_ok, hold_ok, saw_done;
        int          lat, done_at;

        vecs[0] = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
        vecs[1] = '{2'b01, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 1'b0};
        vecs[2] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
        vecs[3] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5] = '{2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
        vecs[6] = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        vecs[7] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};

        reset = 1'b0; clk_enable = 1'b1; start = 1'b0; op = 2'b00;
        operand_a = '0; operand_b = '0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
        tick(); tick();
        check("reset_state", {27'b0, busy, done, div_by_zero, 2'b0, hi, lo}, 64'h0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, h, l, z, lat, busy_ok, hold_ok);
            check($sformatf("vec%0d_hi", i), 64'(h), 64'(vecs[i].exp_hi));
            check($sformatf("vec%0d_lo", i), 64'(l), 64'(vecs[i].exp_lo));
            check($sformatf("vec%0d_dbz", i), 64'(z), 64'(vecs[i].exp_dbz));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
            check($sformatf("vec%0d_busy", i), 64'(busy_ok), 64'd1);
            check($sformatf("vec%0d_hold", i), 64'(hold_ok), 64'd1);
            tick();
            check($sformatf("vec%0d_pulse", i), {62'b0, done, div_by_zero}, 64'd0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            model(rop, ra, rb, mh, ml, mz);
            run_op(rop, ra, rb, h, l, z, lat, busy_ok, hold_ok);
            check($sformatf("rnd%0d_op%0d_%h_%h", i, rop, ra, rb), {h, l}, {mh, ml});
            check($sformatf("rnd%0d_dbz_lat", i), {31'b0, z, 32'(lat)}, {31'b0, mz, 32'd33});
        end

        // Ignored re-start plus four disabled cycles stretch latency to 37.
        start = 1'b1; op = 2'b00; operand_a = 32'd3; operand_b = 32'd4;
        tick();
        start = 1'b0; operand_a = $urandom; operand_b = $urandom;
        done_at = 0;
        for (int n = 1; n <= 60; n++) begin
            start = (n == 5);
            if (n == 5) begin operand_a = 32'd9; operand_b = 32'd9; end
            clk_enable = !(n >= 10 && n <= 13);
            tick();
            if (done) begin done_at = n; break; end
        end
        start = 1'b0; clk_enable = 1'b1;
        check("stall_latency", 64'(done_at), 64'd37);
        check("stall_result", {hi, lo}, {32'd0, 32'd12});
        tick();
        check("stall_no_restart", {63'b0, busy}, 64'd0);

        wr_hi = 1'b1; wr_data = 32'hCAFEF00D;
        tick();
        wr_hi = 1'b0;
        check("wr_hi", 64'(hi), 64'hCAFEF00D);
        wr_lo = 1'b1; wr_data = 32'h12345678;
        tick();
        wr_lo = 1'b0;
        check("wr_lo", {hi, lo}, {32'hCAFEF00D, 32'h12345678});
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hA5A5A5A5;
        tick();
        wr_hi = 1'b0; wr_lo = 1'b0;
        check("wr_both", {hi, lo}, {32'hA5A5A5A5, 32'hA5A5A5A5});

        start = 1'b1; op = 2'b01; operand_a = 32'd2; operand_b = 32'd3;
        wr_hi = 1'b1; wr_data = 32'hDEADBEEF;
        tick();
        start = 1'b0; wr_hi = 1'b0;
        check("start_beats_wr", {31'b0, busy, hi}, {31'b0, 1'b1, 32'hA5A5A5A5});
        tick(); tick(); tick();
        wr_lo = 1'b1; wr_data = 32'h11111111;
        tick();
        wr_lo = 1'b0;
        check("wr_ignored_busy", 64'(lo), 64'hA5A5A5A5);
        lat = 0;
        while (!done && lat < 100) begin tick(); lat++; end
        check("after_busy_wr_result", {hi, lo}, {32'd0, 32'd6});

        wr_hi = 1'b1; wr_data = 32'hCAFEF00D;
        tick();
        wr_hi = 1'b0;
        check("wr_hi_again", 64'(hi), 64'hCAFEF00D);
        start = 1'b1; op = 2'b10; operand_a = 32'd100; operand_b = 32'd7;
        tick();
        start = 1'b0;
        for (int n = 0; n < 10; n++) tick();
        #2 reset = 1'b0;
        #1;
        check("async_reset", {31'b0, busy, hi}, 64'd0);
        check("async_reset_lo", 64'(lo), 64'd0);
        tick(); tick();
        reset = 1'b1;
        saw_done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_cpu_mult_div.md
Name: mips_cpu_mult_div

Overview:
Iterative multiply/divide unit that owns the architectural HI and LO registers. It sits beside the CPU execute stage. It accepts MULT, MULTU, DIV and DIVU operands from the register-file read ports and produces HI/LO results for MFHI/MFLO. The CPU stalls on busy; MTHI/MTLO writes arrive through a direct write port.

Parameters:
WIDTH, 32, operand and result width; only 32 is supported.
DIV_ZERO_LO, 32'hFFFFFFFF, value written to LO on divide by zero.

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
clk_enable  input  1  when low, all state is frozen, including counter, FSM and done
start  input  1  request an operation; sampled only in IDLE
op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU; sampled with start
operand_a  input  32  Rs; multiplicand or dividend
operand_b  input  32  Rt; multiplier or divisor
wr_hi  input  1  MTHI; write wr_data to HI
wr_lo  input  1  MTLO; write wr_data to LO
wr_data  input  32  data for wr_hi/wr_lo
busy  output  1  operation in progress
done  output  1  one-cycle pulse; HI/LO updated this cycle
div_by_zero  output  1  one-cycle pulse coincident with done, for DIV/DIVU with operand_b==0
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, div_by_zero=0. Takes effect immediately, mid-operation included. An aborted operation never produces done.
- FSM states: IDLE -> CALC -> FINISH -> IDLE.
- IDLE:
  - start=1 at edge E0: latch op, magnitudes and sign bits, clear the 64-bit accumulator, counter=0, go to CALC, busy=1.
  - Signed ops take the two's-complement magnitude of each operand; unsigned ops use operands as-is.
- CALC:
  - One iteration per enabled edge, 32 iterations (E1..E32). Counter 0..31; at counter==31 go to FINISH.
  - Multiply: shift-add, one multiplier bit per cycle, LSB first.
  - Divide: restoring, one quotient bit per cycle, MSB first. Partial remainder is 33 bits wide.
- FINISH (edge E0+33):
  - Apply sign fixup and write hi/lo. Pulse done (and div_by_zero if applicable). busy=0. Return to IDLE.
  - Latency is 33 cycles from the start edge to the result edge.
- Results:
  - MULT/MULTU: {hi,lo} = 64-bit product. For MULT the product is negated if the operand signs differ.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed DIV: quotient is negated if the operand signs differ; remainder takes the sign of the dividend (truncating division).
  - 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0. No trap.
  - Divide by zero: hi=operand_a as latched, lo=DIV_ZERO_LO, div_by_zero=1. Same 33-cycle latency.
- start while busy: ignored; no queuing.
- wr_hi/wr_lo:
  - Honoured only in IDLE with start=0; they update at the same edge.
  - wr_hi and wr_lo together write both registers.
  - start=1 in the same cycle takes priority and the writes are discarded.
  - Ignored while busy.
- hi/lo hold their value throughout CALC. Outputs change only at the FINISH edge or on a wr_hi/wr_lo write.
- Operands need only be stable at the start edge. They are not re-sampled afterwards.
- done and div_by_zero are registered; they are low in every cycle except the one after the FINISH edge.
- clk_enable low during CALC: no counter advance and no iteration. Latency is extended by exactly the number of disabled cycles.

Test Plan:
- MULT a=0xFFFFFFFE, b=0x00000003 -> after 33 cycles: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high for exactly 33 cycles.
- MULTU a=0xFFFFFFFE, b=0x00000003 -> hi=0x00000002, lo=0xFFFFFFFA; then DIVU a=0xFFFFFFFF, b=0x00000010 -> lo=0x0FFFFFFF, hi=0x0000000F.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=5, b=0 -> hi=0x00000005, lo=0xFFFFFFFF, div_by_zero and done pulse for one cycle.
- Start MULT 3*4, re-assert start with a=9, b=9 at cycle 5, hold clk_enable low for 4 cycles mid-CALC -> result lo=12, hi=0; done 37 cycles after the first start.
- wr_hi=1, wr_data=0xCAFEF00D in IDLE -> hi=0xCAFEF00D next cycle. Start DIV, drive reset low at cycle 10 -> hi=lo=0, busy=0 immediately, no done pulse.
